pack_fields: RTL and testbench
==============================

# pack_fields

Pipelined, precision-decomposable posit field packer: the inverse of the field extractor. It takes per-lane exponent (signed regime plus fixed exponent bits) and mantissa (hidden bit at the MSB), and produces sign-less posit bit strings in the same format the extractor consumes: regime, then exponent, then mantissa. It sits at the PE result path, after arithmetic and before the register file and write-back. It supports one 32-bit lane, two 16-bit lanes or four 8-bit lanes per transaction, with round-to-nearest-even and saturation.

## Interface
- ES_L_32, 6, exponent field bits, 32-bit mode
- ES_L_16, 4, exponent field bits, 16-bit mode
- ES_L_8, 2, exponent field bits, 8-bit mode
- clk  in  1  clock, all flops on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept this cycle
- mode  in  PRECISION_CONFIG_L  pe_pkg::PRECISION_CONFIG_32B/16B/8B
- exp32  in  ES_L_32+6  {signed regime[5:0], exp bits}
- mant32  in  31-ES_L_32  {hidden, fraction}
- exp16  in  2×(ES_L_16+5)  lane i = exp16[i], same layout
- mant16  in  2×(15-ES_L_16)
- exp8  in  4×(ES_L_8+4)
- mant8  in  4×(7-ES_L_8)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out  out  32  packed posit(s); 16B lane i = out[16i+15:16i], 8B lane i = out[8i+7:8i]
- out_mode  out  PRECISION_CONFIG_L  mode of the transaction on out

## Operation
- Lane width N (32/16/8) and ES are selected by mode, which is captured per transaction and carried through the pipeline. Unused input lanes are ignored.
- Zero: if a lane's hidden mantissa bit is 0, that lane outputs all zeros, with no rounding applied.
- Regime k ≥ 0 encodes as k+1 ones then a 0. Regime k < 0 encodes as −k zeros then a 1.
- Full string is regime string, then ES exp bits, then the fraction (mantissa without hidden bit). The top N bits are kept. If the regime string consumes all N bits, the terminator is dropped.
- Rounding is round-to-nearest-even on the top N bits:
  - guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - Increment when guard & (sticky | lsb).
- Saturation:
  - k > N−2, or a rounded result equal to all ones, gives maxpos (all ones except LSB = 0, e.g. 8'hFE).
  - k < −(N−1), or a nonzero lane rounding to zero, gives minpos (8'h01 / 16'h0001 / 32'h0000_0001).
  - All-ones output is never produced.
- Stage 1 (S1) registers: regime thermometer string, left-aligned {exp, fraction}, shift amount, zero and saturation flags, and mode.
- Stage 2 (S2) registers: lane-merged shifted word, RNE increment, saturation/zero override, and drives out.
- Unsupported mode value: lane outputs are don't-care, but out_valid handshake behaviour is unchanged.

## Timing
- Reset (async, rst_n low): S1/S2 valid flags = 0, out_valid = 0, out = 0, out_mode = PRECISION_CONFIG_32B, in_ready = 1 once reset is released.
- Transfer rules:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - Latency: accepted at edge t → out_valid from edge t+2 (with out_ready high).
- Throughput is 1 transaction/cycle.
- Stall logic:
  - S2 holds when out_valid & ~out_ready.
  - S1 advances when S2 is empty or S2 is transferring.
  - in_ready = ~S1_valid | S1_advance (combinational from out_ready; no skid buffer).
- Capacity is 2 in-flight transactions. While out_valid is high, out and out_mode are stable until transfer.
- Simultaneous input and output transfer on a full pipe: both occur in the same cycle; nothing is lost or duplicated.
- Mode may change on every transaction with no bubble.
- Reset asserted mid-operation drops all in-flight data immediately (asynchronously).

## Test plan
- 32B, exp32 regime 0 / exp 0, mant32 hidden=1 frac=0 → out 32'h8000_0000 at cycle t+2. Same with regime −1 → 32'h4000_0000.
- 8B, all four lanes regime 0, exp 2'b11, mant 5'b1_1010 → out 32'hBABA_BABA, out_mode = 8B.
- 8B rounding and saturation:
  - lane0 regime 2, exp 2'b01, mant 5'b1_1011 → 8'hE7 (guard = 1, sticky = 1).
  - lane1 regime 7 → 8'hFE.
  - lane2 regime −8 → 8'h01.
  - lane3 hidden bit 0 → 8'h00.
- 16B mixed: lane1 regime 3, exp 0, mant 1.0 → 16'hF000; lane0 zero → 16'h0000. Full word 32'hF000_0000.
- Backpressure: stream 5 transactions with out_ready low for 3 cycles mid-stream. in_ready drops after 2 are held, and all 5 appear in order, unchanged, with no duplicates.
- Reset mid-stream: rst_n pulled low with 2 in flight → out_valid is 0 immediately. After release, the next input emerges 2 cycles later and nothing stale is output.

Source files
------------

// File: rtl/pack_fields.sv
// pack_fields: two-stage posit field packer (inverse of the field extractor).
// Turns per-lane {signed regime, exponent} plus {hidden, fraction} into sign-less
// posit strings of 32, 16 or 8 bits with round-to-nearest-even and saturation.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake (in_ready is combinational from out_ready)
//   mode                       lane configuration of the offered transaction
//   exp32 / mant32             one 32-bit lane: {regime[5:0], exp} / {hidden, fraction}
//   exp16 / mant16             two 16-bit lanes, lane i = exp16[i] / mant16[i]
//   exp8  / mant8              four 8-bit lanes, lane i = exp8[i] / mant8[i]
//   out_valid / out_ready      output handshake
//   out                        packed posit(s), lane i at out[N*i +: N]
//   out_mode                   mode of the transaction currently on out

package pe_pkg;
    localparam int PRECISION_CONFIG_L = 2;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;

    // Per-lane stage-1 state: everything is left-aligned in a 64-bit frame so
    // one datapath serves every lane width.
    typedef struct packed {
        logic [63:0] therm;   // regime string, left-aligned
        logic [63:0] ef;      // {exp, fraction}, left-aligned
        logic [5:0]  shamt;   // regime string length = right shift of ef
        logic        zero;
        logic        smax;
        logic        smin;
    } lane_s1_t;
endpackage

module pack_fields
    import pe_pkg::*;
#(
    parameter int ES_L_32 = 6,
    parameter int ES_L_16 = 4,
    parameter int ES_L_8  = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PRECISION_CONFIG_L-1:0]      mode,
    input  logic [ES_L_32+5:0]                 exp32,
    input  logic [30-ES_L_32:0]                mant32,
    input  logic [1:0][ES_L_16+4:0]            exp16,
    input  logic [1:0][14-ES_L_16:0]           mant16,
    input  logic [3:0][ES_L_8+3:0]             exp8,
    input  logic [3:0][6-ES_L_8:0]             mant8,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out,
    output logic [PRECISION_CONFIG_L-1:0]      out_mode
);

    // Lane width in bits for a mode; unsupported codes fall back to 32.
    function automatic logic [5:0] lane_width(input logic [PRECISION_CONFIG_L-1:0] m);
        case (m)
            PRECISION_CONFIG_16B: lane_width = 6'd16;
            PRECISION_CONFIG_8B:  lane_width = 6'd8;
            default:              lane_width = 6'd32;
        endcase
    endfunction

    // Regime thermometer, shift amount and saturation/zero classification.
    function automatic lane_s1_t lane_front(input logic [6:0] k, input logic [63:0] ef,
                                            input logic hid, input logic [5:0] n);
        lane_s1_t    r;
        logic signed [7:0] ks;
        logic signed [7:0] ns;
        logic [6:0]  kneg;
        ks      = $signed({k[6], k});
        ns      = $signed({2'b00, n});
        kneg    = 7'd0 - k;
        r.ef    = ef;
        r.zero  = ~hid;
        r.smax  = (ks > (ns - 8'sd2));
        r.smin  = (ks < (8'sd1 - ns));
        r.therm = 64'd0;
        r.shamt = 6'd0;
        if (!(r.smax || r.smin)) begin
            if (!k[6]) begin
                // k >= 0: k+1 ones then a zero
                r.therm = ~(64'hFFFF_FFFF_FFFF_FFFF >> (k + 7'd1));
                r.shamt = k[5:0] + 6'd2;
            end else begin
                // k < 0: -k zeros then a one
                r.therm = 64'h8000_0000_0000_0000 >> kneg;
                r.shamt = kneg[5:0] + 6'd1;
            end
        end else begin
            r.therm = 64'd0;
        end
        return r;
    endfunction

    // Merge regime with {exp, fraction}, keep the top n bits, RNE, then override.
    function automatic logic [31:0] lane_back(input lane_s1_t s, input logic [5:0] n);
        logic [63:0] word;
        logic [63:0] mask;
        logic [63:0] top;
        logic [63:0] rnd;
        logic [5:0]  gidx;
        logic        guard;
        logic        sticky;
        logic        inc;
        logic [63:0] res;
        word   = s.therm | (s.ef >> s.shamt);
        mask   = ~(64'hFFFF_FFFF_FFFF_FFFF << n);
        top    = word >> (7'd64 - {1'b0, n});
        gidx   = 6'd63 - n;
        guard  = word[gidx];
        sticky = |(word << ({1'b0, n} + 7'd1));
        inc    = guard & (sticky | top[0]);
        rnd    = top + {63'd0, inc};
        if (s.zero) begin
            res = 64'd0;
        end else if (s.smax || (rnd == mask)) begin
            res = mask & ~64'd1;
        end else if (s.smin || (rnd == 64'd0)) begin
            res = 64'd1;
        end else begin
            res = rnd;
        end
        return res[31:0];
    endfunction

    logic [3:0][6:0]                k_s;
    logic [3:0][63:0]               ef_s;
    logic [3:0]                     hid_s;
    lane_s1_t [3:0]                 s1_lane_d;
    lane_s1_t [3:0]                 s1_lane_q;
    logic [PRECISION_CONFIG_L-1:0]  s1_mode_q;
    logic                           s1_valid_q;
    logic                           s1_adv_s;
    logic [3:0][31:0]               res_s;
    logic [31:0]                    out_d;
    logic [31:0]                    out_q;
    logic [PRECISION_CONFIG_L-1:0]  out_mode_q;
    logic                           s2_valid_q;

    assign s1_adv_s  = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s1_adv_s;
    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign out_mode  = out_mode_q;

    // Route input lanes by mode and build the stage-1 lane state.
    always_comb begin
        k_s   = '0;
        ef_s  = '0;
        hid_s = '0;
        case (mode)
            PRECISION_CONFIG_16B: begin
                for (int i = 0; i < 2; i++) begin
                    k_s[i]   = {{2{exp16[i][ES_L_16+4]}}, exp16[i][ES_L_16+4:ES_L_16]};
                    ef_s[i]  = {exp16[i][ES_L_16-1:0], mant16[i][13-ES_L_16:0], 50'd0};
                    hid_s[i] = mant16[i][14-ES_L_16];
                end
            end
            PRECISION_CONFIG_8B: begin
                for (int i = 0; i < 4; i++) begin
                    k_s[i]   = {{3{exp8[i][ES_L_8+3]}}, exp8[i][ES_L_8+3:ES_L_8]};
                    ef_s[i]  = {exp8[i][ES_L_8-1:0], mant8[i][5-ES_L_8:0], 58'd0};
                    hid_s[i] = mant8[i][6-ES_L_8];
                end
            end
            default: begin
                // 32-bit mode; unsupported codes take the same path
                k_s[0]   = {exp32[ES_L_32+5], exp32[ES_L_32+5:ES_L_32]};
                ef_s[0]  = {exp32[ES_L_32-1:0], mant32[29-ES_L_32:0], 34'd0};
                hid_s[0] = mant32[30-ES_L_32];
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            s1_lane_d[i] = lane_front(k_s[i], ef_s[i], hid_s[i], lane_width(mode));
        end
    end

    // Round each lane and merge lanes into the output word.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            res_s[i] = lane_back(s1_lane_q[i], lane_width(s1_mode_q));
        end
        case (s1_mode_q)
            PRECISION_CONFIG_16B: out_d = {res_s[1][15:0], res_s[0][15:0]};
            PRECISION_CONFIG_8B:  out_d = {res_s[3][7:0], res_s[2][7:0], res_s[1][7:0], res_s[0][7:0]};
            default:              out_d = res_s[0];
        endcase
    end

    // Stage 1 register: loads whenever the input side transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lane_q  <= '0;
            s1_mode_q  <= PRECISION_CONFIG_32B;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_lane_q <= s1_lane_d;
                s1_mode_q <= mode;
            end
        end
    end

    // Stage 2 register: holds while the output is stalled, otherwise takes stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            out_q      <= 32'd0;
            out_mode_q <= PRECISION_CONFIG_32B;
        end else begin
            if (s1_adv_s) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s1_adv_s && s1_valid_q) begin
                out_q      <= out_d;
                out_mode_q <= s1_mode_q;
            end
        end
    end

endmodule

// File: tb/tb_pack_fields.sv
module tb_pack_fields;
    import pe_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic              in_ready;
    logic              out_valid;
    logic [1:0]        mode = PRECISION_CONFIG_32B;
    logic [11:0]       exp32 = '0;
    logic [24:0]       mant32 = '0;
    logic [1:0][8:0]   exp16 = '0;
    logic [1:0][10:0]  mant16 = '0;
    logic [3:0][5:0]   exp8 = '0;
    logic [3:0][4:0]   mant8 = '0;
    logic [31:0]       out;
    logic [1:0]        out_mode;

    int errors = 0;
    int checks = 0;
    int saw_block, bad_block, stable_err;
    logic [31:0] got_q[$];
    logic [1:0]  gotm_q[$];
    logic [31:0] exp_q[$];
    logic [1:0]  expm_q[$];

    pack_fields dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .exp32(exp32), .mant32(mant32), .exp16(exp16), .mant16(mant16),
        .exp8(exp8), .mant8(mant8), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    // Reference: build the posit bit string as a list of bits, then cut and round.
    function automatic logic [31:0] ref_lane(int k, int e, int f, int h, int n, int es);
        bit     q[$];
        longint top;
        longint maxv;
        int     fb;
        bit     guard, sticky;
        fb   = n - 2 - es;
        maxv = (longint'(1) << n) - 1;
        if (h == 0) return 32'd0;
        if (k > n - 2) return 32'(maxv - 1);
        if (k < -(n - 1)) return 32'd1;
        if (k >= 0) begin
            repeat (k + 1) q.push_back(1'b1);
            q.push_back(1'b0);
        end else begin
            repeat (-k) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        for (int i = es - 1; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
        for (int i = fb - 1; i >= 0; i--) q.push_back(bit'((f >> i) & 1));
        top = 0;
        for (int i = 0; i < n; i++) top = top * 2 + longint'(q[i]);
        guard  = (q.size() > n) ? q[n] : 1'b0;
        sticky = 1'b0;
        for (int i = n + 1; i < q.size(); i++) sticky |= q[i];
        if (guard && (sticky || (top % 2 == 1))) top = top + 1;
        if (top == maxv) return 32'(maxv - 1);
        if (top == 0) return 32'd1;
        return 32'(top);
    endfunction

    // Place one lane's fields into the input ports (sel: 0=32B, 1=16B, 2=8B).
    task automatic set_lane(int sel, int i, int k, int e, int f, int h);
        case (sel)
            0: begin exp32 = {6'(k), 6'(e)}; mant32 = {1'(h), 24'(f)}; end
            1: begin exp16[i] = {5'(k), 4'(e)}; mant16[i] = {1'(h), 10'(f)}; end
            default: begin exp8[i] = {4'(k), 2'(e)}; mant8[i] = {1'(h), 4'(f)}; end
        endcase
    endtask

    task automatic scramble_inputs();
        exp32 = 12'($urandom); mant32 = 25'($urandom);
        exp16 = 18'($urandom); mant16 = 22'($urandom);
        exp8  = 24'($urandom); mant8  = 20'($urandom);
    endtask

    task automatic gen_txn(output logic [31:0] expv, output logic [1:0] expm);
        int sel, n, es, kw, lanes, k, e, f, h;
        sel   = $urandom_range(0, 2);
        n     = 32 >> sel;
        es    = (sel == 0) ? 6 : (sel == 1) ? 4 : 2;
        kw    = 6 - sel;
        lanes = 1 << sel;
        mode  = (sel == 0) ? PRECISION_CONFIG_32B : (sel == 1) ? PRECISION_CONFIG_16B : PRECISION_CONFIG_8B;
        expm  = mode;
        scramble_inputs();
        expv = 32'd0;
        for (int i = 0; i < lanes; i++) begin
            if ($urandom_range(0, 3) == 0) k = int'($urandom_range(0, (1 << kw) - 1)) - (1 << (kw - 1));
            else k = int'($urandom_range(0, 6)) - 3;
            e = int'($urandom_range(0, (1 << es) - 1));
            f = int'($urandom_range(0, (1 << (n - 2 - es)) - 1));
            h = ($urandom_range(0, 7) != 0) ? 1 : 0;
            set_lane(sel, i, k, e, f, h);
            expv = expv | (ref_lane(k, e, f, h, n, es) << (i * n));
        end
    endtask

    // Send the prepared inputs into an idle pipe and capture the result.
    // lat counts falling edges after the accepting edge until out_valid is seen.
    task automatic send_and_get(output logic [31:0] o, output logic [1:0] m, output int lat);
        bit acc;
        lat = -1; o = '0; m = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (acc) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (out_valid) begin o = out; m = out_mode; lat = c; break; end
            end
        end
        @(posedge clk); #1;
    endtask

    // Cycle-driven stream; records accepted expectations and transferred outputs.
    task automatic run_stream(int n, int stall_at, int stall_len, bit rand_ready, bit rand_valid);
        int acc, cyc, inflight;
        bit have, holding;
        logic [31:0] ev, held;
        logic [1:0]  em;
        exp_q.delete(); expm_q.delete(); got_q.delete(); gotm_q.delete();
        saw_block = 0; bad_block = 0; stable_err = 0;
        acc = 0; cyc = 0; have = 1'b0; holding = 1'b0; held = '0; ev = '0; em = '0;
        while ((acc < n || got_q.size() < n) && cyc < 4000) begin
            if (!have && acc < n) begin gen_txn(ev, em); have = 1'b1; end
            in_valid = have && (rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            else out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge clk);
            inflight = acc - got_q.size();
            if (!in_ready) begin
                saw_block++;
                if (inflight != 2) bad_block++;
            end
            if (out_valid && !out_ready) begin
                if (holding && out !== held) stable_err++;
                held = out; holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
            if (out_valid && out_ready) begin got_q.push_back(out); gotm_q.push_back(out_mode); end
            if (in_valid && in_ready) begin
                exp_q.push_back(ev); expm_q.push_back(em); acc++; have = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #10;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h expected 00000000", out); end
        checks++; if (out_mode !== PRECISION_CONFIG_32B) begin errors++; $display("FAIL reset_out_mode: got %0d expected %0d", out_mode, PRECISION_CONFIG_32B); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_32b_basic();
        logic [31:0] o; logic [1:0] m; int lat;
        scramble_inputs();
        mode = PRECISION_CONFIG_32B;
        set_lane(0, 0, 0, 0, 0, 1);
        send_and_get(o, m, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL 32b_latency: got %0d expected 1", lat); end
        checks++; if (o !== 32'h8000_0000) begin errors++; $display("FAIL 32b_k0: got %h expected 80000000", o); end
        checks++; if (m !== PRECISION_CONFIG_32B) begin errors++; $display("FAIL 32b_mode: got %0d expected %0d", m, PRECISION_CONFIG_32B); end
        set_lane(0, 0, -1, 0, 0, 1);
        send_and_get(o, m, lat);
        checks++; if (o !== 32'h4000_0000) begin errors++; $display("FAIL 32b_kneg1: got %h expected 40000000", o); end
    endtask

    task automatic test_8b_pattern();
        logic [31:0] o; logic [1:0] m; int lat;
        mode = PRECISION_CONFIG_8B;
        for (int i = 0; i < 4; i++) set_lane(2, i, 0, 3, 10, 1);
        send_and_get(o, m, lat);
        checks++; if (o !== 32'hBABA_BABA) begin errors++; $display("FAIL 8b_pattern: got %h expected babababa", o); end
        checks++; if (m !== PRECISION_CONFIG_8B) begin errors++; $display("FAIL 8b_mode: got %0d expected %0d", m, PRECISION_CONFIG_8B); end
    endtask

    task automatic test_8b_round_sat();
        logic [31:0] o; logic [1:0] m; int lat;
        mode = PRECISION_CONFIG_8B;
        set_lane(2, 0, 2, 1, 11, 1);
        set_lane(2, 1, 7, 2, 5, 1);
        set_lane(2, 2, -8, 1, 3, 1);
        set_lane(2, 3, 0, 3, 15, 0);
        send_and_get(o, m, lat);
        checks++; if (o !== 32'h0001_FEE7) begin errors++; $display("FAIL 8b_round_sat: got %h expected 0001fee7", o); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL 8b_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_16b_mixed();
        logic [31:0] o; logic [1:0] m; int lat;
        mode = PRECISION_CONFIG_16B;
        set_lane(1, 1, 3, 0, 0, 1);
        set_lane(1, 0, 5, 3, 77, 0);
        send_and_get(o, m, lat);
        checks++; if (o !== 32'hF000_0000) begin errors++; $display("FAIL 16b_mixed: got %h expected f0000000", o); end
        checks++; if (m !== PRECISION_CONFIG_16B) begin errors++; $display("FAIL 16b_mode: got %0d expected %0d", m, PRECISION_CONFIG_16B); end
    endtask

    task automatic test_random();
        run_stream(200, 0, 0, 1'b1, 1'b1);
        checks++; if (got_q.size() != 200) begin errors++; $display("FAIL random_count: got %0d expected 200", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            checks++; if (gotm_q[i] !== expm_q[i]) begin errors++; $display("FAIL random_mode[%0d]: got %0d expected %0d", i, gotm_q[i], expm_q[i]); end
        end
        checks++; if (stable_err != 0) begin errors++; $display("FAIL random_hold_stable: got %0d changes expected 0", stable_err); end
    endtask

    task automatic test_back_to_back_stall();
        run_stream(5, 2, 3, 1'b0, 1'b0);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", got_q.size()); end
        checks++; if (saw_block == 0) begin errors++; $display("FAIL bp_in_ready_drop: got %0d blocked cycles expected >0", saw_block); end
        checks++; if (bad_block != 0) begin errors++; $display("FAIL bp_capacity: got %0d bad blocked cycles expected 0", bad_block); end
        checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d changes expected 0", stable_err); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] o, ev; logic [1:0] m, em; int lat, stale;
        out_ready = 1'b0;
        gen_txn(ev, em);
        in_valid = 1'b1;
        @(posedge clk); #1;
        gen_txn(ev, em);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_full: got %b expected 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL rst_mid_out: got %h expected 00000000", out); end
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        scramble_inputs();
        mode = PRECISION_CONFIG_32B;
        set_lane(0, 0, -1, 0, 0, 1);
        send_and_get(o, m, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rst_mid_latency: got %0d expected 1", lat); end
        checks++; if (o !== 32'h4000_0000) begin errors++; $display("FAIL rst_mid_out_after: got %h expected 40000000", o); end
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale: got %0d extra outputs expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_32b_basic();
        test_8b_pattern();
        test_8b_round_sat();
        test_16b_mixed();
        test_back_to_back_stall();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
